// File: rtl/uart_loader.sv
// UART program loader: 8N1 receiver that packs bytes little-endian into words
// and writes them to consecutive addresses through a one-entry req/ack port.
module uart_loader #(
    parameter int                    CLK_DIV     = 434,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    ADDR_STEP   = 4,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  uart_rx_i,
    output logic                  mem_wr_req_o,
    input  logic                  mem_wr_ack_i,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    output logic [31:0]           word_cnt_o,
    output logic                  frame_err_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int CW    = $clog2(CLK_DIV);
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [2:0]              bit_cnt_q;
    logic [BCW-1:0]          byte_cnt_q;
    logic [7:0]              shift_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [SYNC_STAGES-1:0]  rx_sync;
    logic                    rxs, rxs_d;
    logic                    clear, stop_tick, byte_valid, word_done, accept, load;
    logic [DATA_WIDTH-1:0]   new_word;

    // Shift a received byte in at the top so the first byte ends up in [7:0].
    function automatic logic [DATA_WIDTH-1:0] pack_byte(input logic [7:0] b,
                                                        input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH+7:0] cat;
        cat = {b, w} >> 8;
        return cat[DATA_WIDTH-1:0];
    endfunction

    assign clear      = rst || !en_i;
    assign rxs        = rx_sync[SYNC_STAGES-1];
    assign stop_tick  = (state_q == STOP) && (cnt_q == CW'(CLK_DIV - 1));
    assign byte_valid = stop_tick && rxs;
    assign word_done  = byte_valid && (byte_cnt_q == BCW'(BYTES - 1));
    assign accept     = mem_wr_req_o && mem_wr_ack_i;
    assign load       = word_done && (!mem_wr_req_o || mem_wr_ack_i);
    assign new_word   = pack_byte(shift_q, word_q);
    assign busy_o     = (state_q != IDLE) || (byte_cnt_q != '0) || mem_wr_req_o;

    always_ff @(posedge clk) begin
        if (clear) begin
            rx_sync <= '1;
            rxs_d   <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[SYNC_STAGES-2:0], uart_rx_i};
            rxs_d   <= rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            word_q      <= '0;
            frame_err_o <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rxs_d && !rxs) state_q <= START;
                end
                START: begin
                    // Mid-start-bit recheck rejects short low glitches silently.
                    if (cnt_q == CW'(CLK_DIV / 2 - 1)) begin
                        cnt_q   <= '0;
                        state_q <= rxs ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CW'(CLK_DIV - 1)) begin
                        cnt_q     <= '0;
                        shift_q   <= {rxs, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (stop_tick) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (rxs) begin
                            word_q     <= new_word;
                            byte_cnt_q <= word_done ? '0 : byte_cnt_q + BCW'(1);
                        end else begin
                            frame_err_o <= 1'b1;
                            byte_cnt_q  <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            mem_wr_req_o  <= 1'b0;
            mem_wr_addr_o <= BASE_ADDR;
            mem_wr_data_o <= '0;
            word_cnt_o    <= '0;
            overflow_o    <= 1'b0;
        end else begin
            if (accept) begin
                mem_wr_addr_o <= mem_wr_addr_o + ADDR_WIDTH'(ADDR_STEP);
                word_cnt_o    <= word_cnt_o + 32'd1;
            end
            if (load) begin
                mem_wr_data_o <= new_word;
                mem_wr_req_o  <= 1'b1;
            end else if (accept) begin
                mem_wr_req_o  <= 1'b0;
            end
            if (word_done && mem_wr_req_o && !mem_wr_ack_i) overflow_o <= 1'b1;
        end
    end

endmodule
